// File: rtl/sram_bist.sv
// sram_bist: SRAM built-in self test driving an sram_controller over a
// req/ready request channel and an in-order rvalid read-return channel.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, cfg_*        run request and its configuration (sampled in CFG)
//   busy, done, pass    run status; done is a 1-cycle pulse at run end
//   err_count, first_*  saturating mismatch count and first-failure capture
//   cur_mode            pattern currently under test
//   mem_*               request channel (req/ready/we/addr/wdata) and read return
module sram_bist #(
  parameter int ADDR_BITS       = 20,
  parameter int DATA_BITS       = 16,
  parameter int ERR_BITS        = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] cfg_addr_lo,
  input  logic [ADDR_BITS-1:0] cfg_addr_hi,
  input  logic [2:0]           cfg_mode,
  input  logic                 cfg_stop_on_err,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_BITS-1:0]  err_count,
  output logic [ADDR_BITS-1:0] first_err_addr,
  output logic [DATA_BITS-1:0] first_err_expected,
  output logic [DATA_BITS-1:0] first_err_actual,
  output logic [2:0]           cur_mode,
  output logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  input  logic                 mem_rvalid
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_WRITE, S_READ, S_DRAIN, S_NEXT, S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [2:0]           mode_q, mode_d, cur_mode_q, cur_mode_d;
  logic                 stop_q, stop_d, cfg_ok_q, cfg_ok_d;
  logic                 halt_q, halt_d, pass_q, pass_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, chk_addr_q, chk_addr_d;
  logic [OW-1:0]        outst_q, outst_d;
  logic                 cmp_valid_q, cmp_valid_d;
  logic [DATA_BITS-1:0] cmp_exp_q, cmp_exp_d, cmp_act_q, cmp_act_d;
  logic [ADDR_BITS-1:0] cmp_addr_q, cmp_addr_d;
  logic [ERR_BITS-1:0]  err_count_q, err_count_d;
  logic [ADDR_BITS-1:0] first_err_addr_q, first_err_addr_d;
  logic [DATA_BITS-1:0] first_err_expected_q, first_err_expected_d;
  logic [DATA_BITS-1:0] first_err_actual_q, first_err_actual_d;

  logic rd_acc, rv_acc, mismatch, pass_now, cfg_ok_now;

  function automatic logic [DATA_BITS-1:0] pattern(input logic [2:0] m,
                                                   input logic [ADDR_BITS-1:0] a);
    logic [DATA_BITS-1:0] p;
    logic [ADDR_BITS-1:0] sh;
    p  = '0;
    sh = a % ADDR_BITS'(DATA_BITS);
    case (m)
      3'd1: p = '1;
      3'd2: for (int unsigned i = 0; i < DATA_BITS; i++) p[i] = (i[0] == a[0]);
      3'd3: p = DATA_BITS'(a);
      3'd4: p = DATA_BITS'(1) << sh;
      default: p = '0;
    endcase
    return p;
  endfunction

  always_comb begin
    state_d              = state_q;
    lo_d                 = lo_q;
    hi_d                 = hi_q;
    mode_d               = mode_q;
    cur_mode_d           = cur_mode_q;
    stop_d               = stop_q;
    cfg_ok_d             = cfg_ok_q;
    halt_d               = halt_q;
    pass_d               = pass_q;
    addr_d               = addr_q;
    chk_addr_d           = chk_addr_q;
    cmp_valid_d          = 1'b0;
    cmp_exp_d            = cmp_exp_q;
    cmp_act_d            = cmp_act_q;
    cmp_addr_d           = cmp_addr_q;
    err_count_d          = err_count_q;
    first_err_addr_d     = first_err_addr_q;
    first_err_expected_d = first_err_expected_q;
    first_err_actual_d   = first_err_actual_q;
    busy                 = 1'b0;
    done                 = 1'b0;
    mem_req              = 1'b0;
    mem_we               = 1'b0;
    rd_acc               = 1'b0;

    // Returns only count while reads are in flight, so stale returns after reset are dropped.
    rv_acc     = mem_rvalid && (outst_q != '0);
    mismatch   = cmp_valid_q && (cmp_exp_q != cmp_act_q);
    pass_now   = cfg_ok_q && (err_count_q == '0);
    cfg_ok_now = (cfg_addr_lo <= cfg_addr_hi) && !(cfg_mode inside {3'd5, 3'd6});

    if (rv_acc) begin
      cmp_valid_d = 1'b1;
      cmp_exp_d   = pattern(cur_mode_q, chk_addr_q);
      cmp_act_d   = mem_rdata;
      cmp_addr_d  = chk_addr_q;
      chk_addr_d  = chk_addr_q + ADDR_BITS'(1);
    end

    // Once halted, remaining returns are still compared but no longer counted.
    if (mismatch && !halt_q) begin
      if (err_count_q != '1) err_count_d = err_count_q + ERR_BITS'(1);
      if (err_count_q == '0) begin
        first_err_addr_d     = cmp_addr_q;
        first_err_expected_d = cmp_exp_q;
        first_err_actual_d   = cmp_act_q;
      end
      if (stop_q) halt_d = 1'b1;
    end

    case (state_q)
      S_IDLE: if (start) state_d = S_CFG;
      S_CFG: begin
        busy                 = 1'b1;
        lo_d                 = cfg_addr_lo;
        hi_d                 = cfg_addr_hi;
        mode_d               = cfg_mode;
        stop_d               = cfg_stop_on_err;
        cfg_ok_d             = cfg_ok_now;
        cur_mode_d           = (cfg_mode == 3'd7) ? 3'd0 : cfg_mode;
        addr_d               = cfg_addr_lo;
        chk_addr_d           = cfg_addr_lo;
        halt_d               = 1'b0;
        pass_d               = 1'b0;
        cmp_valid_d          = 1'b0;
        err_count_d          = '0;
        first_err_addr_d     = '0;
        first_err_expected_d = '0;
        first_err_actual_d   = '0;
        state_d              = cfg_ok_now ? S_WRITE : S_FINISH;
      end
      S_WRITE: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          if (addr_q == hi_q) begin
            addr_d  = lo_q;
            state_d = S_READ;
          end else begin
            addr_d = addr_q + ADDR_BITS'(1);
          end
        end
      end
      S_READ: begin
        busy = 1'b1;
        if (halt_q) begin
          state_d = S_DRAIN;
        end else if (outst_q < OW'(MAX_OUTSTANDING)) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            rd_acc = 1'b1;
            if (addr_q == hi_q) begin
              addr_d  = lo_q;
              state_d = S_DRAIN;
            end else begin
              addr_d = addr_q + ADDR_BITS'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Wait for the registered compare of the last return as well.
        if ((outst_q == '0) && !cmp_valid_q) state_d = halt_q ? S_FINISH : S_NEXT;
      end
      S_NEXT: begin
        busy       = 1'b1;
        chk_addr_d = lo_q;
        if ((mode_q == 3'd7) && (cur_mode_q != 3'd4)) begin
          cur_mode_d = cur_mode_q + 3'd1;
          state_d    = S_WRITE;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        pass_d  = pass_now;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    outst_d = outst_q + OW'(rd_acc) - OW'(rv_acc);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= S_IDLE;
      lo_q                 <= '0;
      hi_q                 <= '0;
      mode_q               <= '0;
      cur_mode_q           <= '0;
      stop_q               <= 1'b0;
      cfg_ok_q             <= 1'b0;
      halt_q               <= 1'b0;
      pass_q               <= 1'b0;
      addr_q               <= '0;
      chk_addr_q           <= '0;
      outst_q              <= '0;
      cmp_valid_q          <= 1'b0;
      cmp_exp_q            <= '0;
      cmp_act_q            <= '0;
      cmp_addr_q           <= '0;
      err_count_q          <= '0;
      first_err_addr_q     <= '0;
      first_err_expected_q <= '0;
      first_err_actual_q   <= '0;
    end else begin
      state_q              <= state_d;
      lo_q                 <= lo_d;
      hi_q                 <= hi_d;
      mode_q               <= mode_d;
      cur_mode_q           <= cur_mode_d;
      stop_q               <= stop_d;
      cfg_ok_q             <= cfg_ok_d;
      halt_q               <= halt_d;
      pass_q               <= pass_d;
      addr_q               <= addr_d;
      chk_addr_q           <= chk_addr_d;
      outst_q              <= outst_d;
      cmp_valid_q          <= cmp_valid_d;
      cmp_exp_q            <= cmp_exp_d;
      cmp_act_q            <= cmp_act_d;
      cmp_addr_q           <= cmp_addr_d;
      err_count_q          <= err_count_d;
      first_err_addr_q     <= first_err_addr_d;
      first_err_expected_q <= first_err_expected_d;
      first_err_actual_q   <= first_err_actual_d;
    end
  end

  // pass is presented during the FINISH cycle itself, then held.
  assign pass               = (state_q == S_FINISH) ? pass_now : pass_q;
  assign err_count          = err_count_q;
  assign first_err_addr     = first_err_addr_q;
  assign first_err_expected = first_err_expected_q;
  assign first_err_actual   = first_err_actual_q;
  assign cur_mode           = cur_mode_q;
  assign mem_addr           = addr_q;
  assign mem_wdata          = pattern(cur_mode_q, addr_q);

endmodule

// File: tb/tb_sram_bist.sv
module tb_sram_bist;
  localparam int AB = 20, DB = 16, EB = 16, MO = 4;

  logic clk = 1'b0;
  logic reset_n, start, cfg_stop_on_err;
  logic [AB-1:0] cfg_addr_lo, cfg_addr_hi;
  logic [2:0] cfg_mode;
  logic busy, done, pass;
  logic [EB-1:0] err_count;
  logic [AB-1:0] first_err_addr;
  logic [DB-1:0] first_err_expected, first_err_actual;
  logic [2:0] cur_mode;
  logic mem_req, mem_ready, mem_we, mem_rvalid;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_bist #(.ADDR_BITS(AB), .DATA_BITS(DB), .ERR_BITS(EB), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_addr_lo(cfg_addr_lo), .cfg_addr_hi(cfg_addr_hi), .cfg_mode(cfg_mode),
    .cfg_stop_on_err(cfg_stop_on_err),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_expected(first_err_expected),
    .first_err_actual(first_err_actual), .cur_mode(cur_mode),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  typedef struct { logic we; logic [AB-1:0] addr; logic [DB-1:0] wdata; } req_t;
  typedef struct { logic pass; logic [EB-1:0] errs; logic [AB-1:0] faddr;
                   logic [DB-1:0] fexp; logic [DB-1:0] fact; logic stop; } res_t;

  req_t req_q[$];
  res_t res_q[$];
  logic [DB-1:0] mem [int];
  logic [DB-1:0] pend_data[$];
  int pend_due[$];
  int errors = 0, checks = 0;
  int cyc = 0, last_due = 0;
  int stall_pct = 0, lat_min = 2, lat_max = 2;
  bit fault_en = 0;
  int fault_addr = 0, fault_bit = 0;
  int tb_outst = 0, max_outst = 0, late_xfer = 0, done_cnt = 0, done_base = 0;
  bit stop_run = 0;
  int mon_lat, mon_due;
  req_t mon_r;
  res_t mon_e;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference patterns from the plain arithmetic definition.
  function automatic logic [DB-1:0] pat(int m, int a);
    case (m)
      1: return 16'hFFFF;
      2: return (a % 2 == 0) ? 16'h5555 : 16'hAAAA;
      3: return 16'(a % 65536);
      4: return 16'(1 << (a % 16));
      default: return 16'h0000;
    endcase
  endfunction

  // Stuck-at-0 cell model applied on read.
  function automatic logic [DB-1:0] read_value(int a, logic [DB-1:0] d);
    if (fault_en && a == fault_addr) return d & ~(16'(1 << fault_bit));
    return d;
  endfunction

  // Controller model: ready stalls and in-order delayed read returns.
  initial begin
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      mem_ready = ($urandom_range(0, 99) >= stall_pct);
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_data.pop_front();
        void'(pend_due.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = DB'($urandom);
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (mem_rvalid) tb_outst--;
    if (mem_req && mem_ready) begin
      if (stop_run && err_count != 0) late_xfer++;
      if (mem_we) begin
        mem[int'(mem_addr)] = mem_wdata;
      end else begin
        mon_lat = $urandom_range(lat_min, lat_max);
        mon_due = cyc + mon_lat;
        if (mon_due <= last_due) mon_due = last_due + 1;
        last_due = mon_due;
        pend_due.push_back(mon_due);
        pend_data.push_back(read_value(int'(mem_addr),
                            mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 16'h0));
        tb_outst++;
      end
      if (req_q.size() == 0) begin
        check("unexpected_req", 1, 0);
      end else begin
        mon_r = req_q.pop_front();
        check("req_we", mem_we, mon_r.we);
        check("req_addr", mem_addr, mon_r.addr);
        if (mon_r.we) check("req_wdata", mem_wdata, mon_r.wdata);
      end
    end
    if (tb_outst > max_outst) max_outst = tb_outst;
    if (done) begin
      done_cnt++;
      if (res_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = res_q.pop_front();
        check("pass", pass, mon_e.pass);
        check("err_count", err_count, mon_e.errs);
        check("first_err_addr", first_err_addr, mon_e.faddr);
        check("first_err_expected", first_err_expected, mon_e.fexp);
        check("first_err_actual", first_err_actual, mon_e.fact);
        check("outst_at_done", tb_outst, 0);
        check("max_outst_ok", max_outst <= MO, 1);
        if (mon_e.stop) check("req_after_err", late_xfer, 0);
        else check("reqs_left", req_q.size(), 0);
      end
      req_q.delete();
    end
  end

  task automatic launch(int lo, int hi, int mode, bit stop, bit poke);
    res_t e;
    int n;
    bit valid, halted;
    int ms[$];
    valid = (lo <= hi) && mode != 5 && mode != 6;
    e.pass = 0; e.errs = '0; e.faddr = '0; e.fexp = '0; e.fact = '0; e.stop = stop;
    halted = 0;
    if (valid) begin
      if (mode == 7) ms = '{0, 1, 2, 3, 4}; else ms = '{mode};
      foreach (ms[k]) begin
        for (int a = lo; a <= hi; a++) req_q.push_back('{1'b1, AB'(a), pat(ms[k], a)});
        for (int a = lo; a <= hi; a++) begin
          logic [DB-1:0] d, r;
          d = pat(ms[k], a);
          r = read_value(a, d);
          req_q.push_back('{1'b0, AB'(a), 16'h0});
          if (r != d && !halted) begin
            if (e.errs == 0) begin e.faddr = AB'(a); e.fexp = d; e.fact = r; end
            if (e.errs != '1) e.errs = e.errs + 1'b1;
            if (stop) halted = 1;
          end
        end
      end
      e.pass = (e.errs == 0);
    end
    res_q.push_back(e);
    max_outst = 0; late_xfer = 0; stop_run = stop; done_base = done_cnt;
    @(posedge clk); #1;
    cfg_addr_lo = AB'(lo); cfg_addr_hi = AB'(hi); cfg_mode = 3'(mode);
    cfg_stop_on_err = stop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_in_cfg", busy, 1);
    end while (!(mem_req || done) && n < 10);
    check("first_out_latency", n, 2);
    if (poke) begin
      @(posedge clk); #1;
      cfg_mode = 3'd5; cfg_addr_lo = '1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic recover();
    @(posedge clk); #2;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    res_q.delete(); req_q.delete(); pend_data.delete(); pend_due.delete();
    tb_outst = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_done(int budget);
    int i;
    i = 0;
    while (done_cnt == done_base && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("done_within_budget", done_cnt != done_base, 1);
    if (done_cnt == done_base) recover();
    repeat (2) @(posedge clk);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_ctrl"}, {busy, done, pass, mem_req, mem_we, cur_mode}, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_first_addr"}, first_err_addr, 0);
    check({tag, "_first_data"}, {first_err_expected, first_err_actual}, 0);
  endtask

  initial begin
    int modes[6];
    int i, lo;
    modes = '{0, 1, 2, 3, 4, 7};
    reset_n = 1'b0; start = 1'b0; cfg_addr_lo = '0; cfg_addr_hi = '0;
    cfg_mode = '0; cfg_stop_on_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) reset_n = 1'b1;

    // Ideal controller, address pattern; a start while busy must be ignored.
    launch(0, 15, 3, 0, 1); wait_done(5000);

    // Bit 3 stuck at 0 on address 5, all patterns.
    fault_en = 1; fault_addr = 5; fault_bit = 3;
    launch(0, 15, 7, 0, 0); wait_done(5000);
    launch(0, 15, 7, 1, 0); wait_done(5000);
    fault_en = 0;

    // Random stalls and return latency.
    stall_pct = 30; lat_min = 1; lat_max = 6;
    launch(100, 163, 4, 0, 0); wait_done(5000);
    stall_pct = 0; lat_min = 2; lat_max = 2;

    // Invalid configurations and the top-of-range single address.
    launch(10, 9, 0, 0, 0); wait_done(50);
    launch(0, 3, 5, 0, 0); wait_done(50);
    launch((1 << AB) - 1, (1 << AB) - 1, 4, 0, 0); wait_done(200);

    // Reset mid-READ with three reads in flight.
    lat_min = 6; lat_max = 6;
    launch(0, 63, 1, 0, 0);
    i = 0;
    do begin
      @(negedge clk); #1;
      i++;
    end while (tb_outst != 3 && i < 2000);
    check("outst_before_reset", tb_outst, 3);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1 check_zero("mid_run_reset");
    res_q.delete(); req_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    i = 0;
    while (pend_due.size() > 0 && i < 100) begin @(posedge clk); i++; end
    repeat (4) @(negedge clk);
    check("stale_rvalid_err", err_count, 0);
    check("stale_rvalid_busy", busy, 0);
    tb_outst = 0;
    lat_min = 2; lat_max = 2;
    launch(0, 15, 2, 0, 0); wait_done(5000);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      lo = $urandom_range(0, 300);
      i = lo + $urandom_range(0, 30);
      fault_en = $urandom_range(0, 1);
      fault_addr = $urandom_range(lo, i);
      fault_bit = $urandom_range(0, 15);
      stall_pct = $urandom_range(0, 50);
      lat_min = $urandom_range(1, 3);
      lat_max = lat_min + $urandom_range(0, 3);
      launch(lo, i, modes[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), 0);
      wait_done(8000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
